aes_pipe_scheduler: RTL and testbench

//  Shares one fully pipelined AES core (AESEncoder or AESDecoder, LATENCY-deep, no stall) among N_REQ requesters.

---
 rtl/aes_pipe_scheduler_pkg.sv | 22 ++
 rtl/aes_sched_rsp_fifo.sv | 53 +++++
 rtl/aes_pipe_scheduler.sv | 179 +++++++++++++++++
 tb/tb_aes_pipe_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pipe_scheduler_pkg.sv
// Shared types for the AES pipe scheduler: block/byte types and the requester tag
// that travels alongside each block through the core.
package aes_pipe_scheduler_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  // Wide enough for the largest supported requester count (8).
  localparam int SCHED_ID_W = 3;

  typedef logic [SCHED_ID_W-1:0] sched_id_t;

  typedef struct packed {
    logic      vld;
    sched_id_t id;
  } sched_tag_t;

  function automatic sched_id_t nextId(sched_id_t id, int nReq);
    return (int'(id) == nReq - 1) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/aes_sched_rsp_fifo.sv
// Per-requester response FIFO. Push and pop may share an edge, including when full;
// the head seen by a pop is always the pre-edge head (no bypass).
module aes_sched_rsp_fifo
  import aes_pipe_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  state_t                 pushData,
  input  logic                   pop,
  output state_t                 headData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  state_t           mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_pipe_scheduler.sv
// Round-robin scheduler sharing one pipelined AES core among N_REQ requesters with
// credit-bounded response FIFOs. Define AES_SCHED_STATS_EN for per-requester counters.
module aes_pipe_scheduler
  import aes_pipe_scheduler_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int KEY_SIZE  = 128,
  parameter int LATENCY   = 10,
  parameter int RSP_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic   [N_REQ-1:0]                req_valid,
  output logic   [N_REQ-1:0]                req_ready,
  input  state_t [N_REQ-1:0]                req_data,
  input  logic   [N_REQ-1:0][KEY_SIZE-1:0]  req_key,
  output logic   [N_REQ-1:0]                rsp_valid,
  input  logic   [N_REQ-1:0]                rsp_ready,
  output state_t [N_REQ-1:0]                rsp_data,
  output state_t                            core_data,
  output logic   [KEY_SIZE-1:0]             core_key,
  input  state_t                            core_result,
  output logic                              busy
`ifdef AES_SCHED_STATS_EN
  ,
  output logic   [N_REQ-1:0][31:0]          stat_issued,
  output logic   [N_REQ-1:0][31:0]          stat_starved
`endif
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  logic [CNT_W-1:0]    outstanding [N_REQ];
  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    popFire;
  logic [N_REQ-1:0]    pushVec;
  logic                accept;
  sched_id_t           rrPtr;
  sched_id_t           grantId;
  state_t              selData;
  logic [KEY_SIZE-1:0] selKey;
  sched_tag_t          tagPipe [LATENCY+1];
  sched_tag_t          retTag;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = req_valid[i] && (outstanding[i] < CNT_W'(RSP_DEPTH));
  end

  // Scan from the pointer upward with wrap; padding to 8 keeps index widths exact.
  always_comb begin
    logic [7:0] eligPad;
    logic [7:0] grantPad;
    logic [3:0] sum;
    logic       found;
    eligPad  = 8'(eligible);
    grantPad = '0;
    grantId  = '0;
    found    = 1'b0;
    sum      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rrPtr} + 4'(k);
      if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
      if (!found && eligPad[sum[2:0]]) begin
        found             = 1'b1;
        grantPad[sum[2:0]] = 1'b1;
        grantId           = sum[2:0];
      end
    end
    grant = reset ? '0 : grantPad[N_REQ-1:0];
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign popFire   = rsp_valid & rsp_ready;

  always_comb begin
    selData = '0;
    selKey  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        selData = req_data[i];
        selKey  = req_key[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rrPtr     <= '0;
      core_data <= '0;
      core_key  <= '0;
    end else if (accept) begin
      rrPtr     <= nextId(grantId, N_REQ);
      core_data <= selData;
      core_key  <= selKey;
    end else begin
      core_data <= '0;
      core_key  <= '0;
    end
  end

  // Tag rides beside the core so its last stage lines up with core_result.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j <= LATENCY; j++) tagPipe[j] <= '0;
    end else begin
      tagPipe[0] <= '{vld: accept, id: grantId};
      for (int j = 1; j <= LATENCY; j++) tagPipe[j] <= tagPipe[j-1];
    end
  end

  always_comb begin
    retTag  = tagPipe[LATENCY];
    pushVec = '0;
    for (int i = 0; i < N_REQ; i++)
      pushVec[i] = retTag.vld && (retTag.id == sched_id_t'(i));
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        outstanding[i] <= '0;
      end else begin
        case ({grant[i], popFire[i]})
          2'b10:   outstanding[i] <= outstanding[i] + 1'b1;
          2'b01:   outstanding[i] <= outstanding[i] - 1'b1;
          default: outstanding[i] <= outstanding[i];
        endcase
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N_REQ; i++) busy = busy | (outstanding[i] != '0);
  end

  for (genvar i = 0; i < N_REQ; i++) begin : gRsp
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    logic             unusedFifoStatus;

    aes_sched_rsp_fifo #(.DEPTH(RSP_DEPTH)) uFifo (
      .clock    (clock),
      .reset    (reset),
      .push     (pushVec[i]),
      .pushData (core_result),
      .pop      (rsp_ready[i]),
      .headData (rsp_data[i]),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
    );

    assign rsp_valid[i]     = !fifoEmpty;
    assign unusedFifoStatus = ^{fifoFull, fifoCount};
  end

`ifdef AES_SCHED_STATS_EN
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        stat_issued[i]  <= '0;
        stat_starved[i] <= '0;
      end else begin
        if (grant[i] && (stat_issued[i] != '1))
          stat_issued[i] <= stat_issued[i] + 1'b1;
        if (req_valid[i] && !eligible[i] && (stat_starved[i] != '1))
          stat_starved[i] <= stat_starved[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Self-checking bench for aes_pipe_scheduler: a stand-in pipelined core plus a
// queue-based model of per-requester responses, credits and round-robin order.
module tb_aes_pipe_scheduler;

  localparam int N  = 4;
  localparam int L  = 10;
  localparam int D  = 4;
  localparam int KS = 128;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N-1:0][127:0]    req_data;
  logic [N-1:0][KS-1:0]   req_key;
  logic [N-1:0]           rsp_valid;
  logic [N-1:0]           rsp_ready;
  logic [N-1:0][127:0]    rsp_data;
  logic [127:0]           core_data;
  logic [KS-1:0]          core_key;
  logic [127:0]           core_result;
  logic                   busy;
`ifdef AES_SCHED_STATS_EN
  logic [N-1:0][31:0]     stat_issued;
  logic [N-1:0][31:0]     stat_starved;
`endif

  always #5 clock = ~clock;

  aes_pipe_scheduler #(.N_REQ(N), .KEY_SIZE(KS), .LATENCY(L), .RSP_DEPTH(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_key     (req_key),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .core_data   (core_data),
    .core_key    (core_key),
    .core_result (core_result),
    .busy        (busy)
`ifdef AES_SCHED_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_starved(stat_starved)
`endif
  );

  // Stand-in for the AES core: a fixed keyed mapping behind an L-deep delay line.
  function automatic logic [127:0] cipher(logic [127:0] d, logic [KS-1:0] k);
    return {d[95:0], d[127:96]} ^ k[127:0] ^ {d[7:0], 120'h0} ^
           128'h5a3c96e10f87d24b1e2d3c4b5a697887;
  endfunction

  logic [127:0] corePipe [L];
  always @(posedge clock) begin
    corePipe[0] <= cipher(core_data, core_key);
    for (int j = 1; j < L; j++) corePipe[j] <= corePipe[j-1];
  end
  assign core_result = corePipe[L-1];

  logic [127:0] expQ   [N][$];
  int           readyQ [N][$];
  int           mPtr;
  int           edgeCount;
  logic [127:0] mCoreData;
  logic [KS-1:0] mCoreKey;
  int           passCount;
  int           failCount;
  int           checkCount;
  int           dutAccepts;
  bit           checkEn;

  task automatic checkOutput(string tag, logic [127:0] obs, logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(logic [N-1:0] valid, logic [N-1:0] ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  function automatic logic [127:0] randBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic tick();
    logic [N-1:0] expGrant;
    logic [N-1:0] expValid;
    logic         expBusy;
    int           g;
    @(negedge clock);
    expGrant = '0;
    g        = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        int idx = (mPtr + k) % N;
        if (g < 0 && req_valid[idx] && expQ[idx].size() < D) begin
          g             = idx;
          expGrant[idx] = 1'b1;
        end
      end
    end
    expValid = '0;
    expBusy  = 1'b0;
    for (int i = 0; i < N; i++) begin
      expValid[i] = (readyQ[i].size() > 0) && (readyQ[i][0] <= edgeCount);
      if (expQ[i].size() > 0) expBusy = 1'b1;
    end
    if (checkEn) begin
      checkOutput("req_ready", 128'(req_ready), 128'(expGrant));
      checkOutput("rsp_valid", 128'(rsp_valid), 128'(expValid));
      checkOutput("busy", 128'(busy), 128'(expBusy));
      checkOutput("core_data", core_data, mCoreData);
      checkOutput("core_key", core_key, mCoreKey);
      for (int i = 0; i < N; i++)
        if (expValid[i]) checkOutput($sformatf("rsp_data%0d", i), rsp_data[i], expQ[i][0]);
    end
    dutAccepts += $countones(req_valid & req_ready);
    @(posedge clock);
    edgeCount++;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        expQ[i].delete();
        readyQ[i].delete();
      end
      mPtr      = 0;
      mCoreData = '0;
      mCoreKey  = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (expValid[i] && rsp_ready[i]) begin
          void'(expQ[i].pop_front());
          void'(readyQ[i].pop_front());
        end
      end
      if (g >= 0) begin
        expQ[g].push_back(cipher(req_data[g], req_key[g]));
        readyQ[g].push_back(edgeCount + L + 1);
        mPtr      = (g + 1) % N;
        mCoreData = req_data[g];
        mCoreKey  = req_key[g];
      end else begin
        mCoreData = '0;
        mCoreKey  = '0;
      end
    end
    #1;
  endtask

  task automatic randomizeData();
    for (int i = 0; i < N; i++) begin
      req_data[i] = randBlock();
      req_key[i]  = randBlock();
    end
  endtask

  initial begin
    int           lat;
    int           base;
    int           issued;
    int           bound;
    logic [N-1:0] sawValid;
    logic [127:0] plain;

    passCount  = 0;
    failCount  = 0;
    checkCount = 0;
    dutAccepts = 0;
    edgeCount  = 0;
    mPtr       = 0;
    mCoreData  = '0;
    mCoreKey   = '0;
    checkEn    = 1'b0;
    reset      = 1'b1;
    req_data   = '0;
    req_key    = '0;
    applyStimulus('0, '0);

    tick();
    tick();
    checkEn = 1'b1;
    applyStimulus('1, '1);
    tick();
    reset = 1'b0;
    applyStimulus('0, '0);
    tick();

    $display("[TB] single block on requester 0");
    req_data[0] = 128'h00112233445566778899aabbccddeeff;
    req_key[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    applyStimulus(4'b0001, 4'b0000);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    lat = 0;
    while (!rsp_valid[0] && lat < 30) begin
      tick();
      lat++;
    end
    checkOutput("accept_to_rsp_latency", 128'(lat), 128'(L + 1));
    applyStimulus(4'b0000, 4'b0001);
    tick();
    tick();

    $display("[TB] all requesters continuously valid");
    base = dutAccepts;
    applyStimulus('1, '1);
    for (int c = 0; c < 40; c++) begin
      randomizeData();
      tick();
    end
    checkOutput("full_utilisation_accepts", 128'(dutAccepts - base), 128'(40));
    applyStimulus('0, '1);
    for (int c = 0; c < 16; c++) tick();

    $display("[TB] credit limit on requester 1");
    base = dutAccepts;
    applyStimulus(4'b0010, 4'b0000);
    for (int c = 0; c < 20; c++) tick();
    checkOutput("credit_limit_accepts", 128'(dutAccepts - base), 128'(D));
    checkOutput("credit_limit_ready", 128'(req_ready[1]), 128'(0));
    applyStimulus(4'b0010, 4'b0010);
    tick();
    applyStimulus(4'b0010, 4'b0000);
    for (int c = 0; c < 15; c++) tick();
    checkOutput("credit_after_one_pop", 128'(dutAccepts - base), 128'(D + 1));
    applyStimulus('0, '1);
    for (int c = 0; c < 20; c++) tick();

    $display("[TB] eight back-to-back blocks on requester 2");
    plain = 128'h3243f6a8885a308d313198a2e0370734;
    req_key[2] = randBlock();
    base   = dutAccepts;
    issued = 0;
    bound  = 0;
    applyStimulus(4'b0100, 4'b0100);
    while (issued < 8 && bound < 80) begin
      req_data[2] = plain ^ 128'(issued);
      tick();
      issued = dutAccepts - base;
      bound++;
    end
    checkOutput("req2_burst_accepts", 128'(issued), 128'(8));
    applyStimulus('0, '1);
    for (int c = 0; c < 20; c++) tick();

    $display("[TB] reset with blocks in flight");
    applyStimulus('1, '1);
    for (int c = 0; c < 6; c++) begin
      randomizeData();
      tick();
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    applyStimulus('0, '1);
    sawValid = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      sawValid = sawValid | rsp_valid;
    end
    checkOutput("no_rsp_after_reset", 128'(sawValid), 128'(0));
    checkOutput("idle_after_reset", 128'(busy), 128'(0));
    req_data[0] = randBlock();
    req_key[0]  = randBlock();
    applyStimulus(4'b0001, 4'b0000);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    lat = 0;
    while (!rsp_valid[0] && lat < 30) begin
      tick();
      lat++;
    end
    checkOutput("post_reset_latency", 128'(lat), 128'(L + 1));
    applyStimulus(4'b0000, 4'b0001);
    tick();
    tick();

    $display("[TB] requester 3 at its credit limit with sporadic pops");
    for (int c = 0; c < 60; c++) begin
      req_data[3] = randBlock();
      applyStimulus(4'b1000, {($urandom_range(0, 3) == 0), 3'b000});
      tick();
    end
    applyStimulus('0, '1);
    for (int c = 0; c < 20; c++) tick();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 300; c++) begin
      randomizeData();
      applyStimulus(N'($urandom), N'($urandom));
      tick();
    end
    applyStimulus('0, '1);
    for (int c = 0; c < 30; c++) tick();
    checkOutput("drained_busy", 128'(busy), 128'(0));
    checkOutput("drained_rsp_valid", 128'(rsp_valid), 128'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
